// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: ALU function codes, instruction field positions, issue FSM states.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 16;
  localparam int IMM_W      = 6;

  localparam int FUNC_MSB = 15;
  localparam int FUNC_LSB = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS1_MSB  = 8;
  localparam int RS1_LSB  = 6;
  localparam int RS2_MSB  = 5;
  localparam int RS2_LSB  = 3;
  localparam int IMM_MSB  = 5;
  localparam int IMM_LSB  = 0;

  // Codes outside this set are reserved.
  typedef enum logic [3:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    ADDI = 4'h2
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } issue_state_t;

  function automatic logic func_is_legal(input logic [3:0] f);
    return (f == ADD) || (f == SUB) || (f == ADDI);
  endfunction

endpackage

// File: rtl/alu_issue.sv
// ALU issue FSM: accepts one instruction per 4 cycles (write-back 3 cycles after handshake), ready only in IDLE.
// ALU_ISSUE_ILLEGAL_EN: reserved funcs raise err_o in WB and suppress the RF write.
module alu_issue
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  instr_valid_i,
  input  logic [INSTR_W-1:0]    instr_i,
  output logic                  instr_ready_o,
  output logic [REG_ADDR_W-1:0] rf_raddr1_o,
  output logic [REG_ADDR_W-1:0] rf_raddr2_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata1_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata2_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output func_t                 func_o,
  output logic [IMM_W-1:0]      imm_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  done_o,
  output logic                  err_o
);

  issue_state_t          r_state;
  issue_state_t          w_state_nxt;
  logic [INSTR_W-1:0]    r_instr;
  logic [DATA_WIDTH-1:0] r_rs1;
  logic [DATA_WIDTH-1:0] r_rs2;
  func_t                 r_func;
  logic [IMM_W-1:0]      r_imm;
  logic                  w_accept;
  logic                  w_wb;
  logic                  w_rd_nz;

  assign w_accept = instr_valid_i && (r_state == IDLE);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = READ;
      READ:    w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_instr <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_func  <= ADD;
      r_imm   <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= instr_i;
      end
      // RF read data arrives during EXEC; operands then stay frozen through WB.
      if (r_state == EXEC) begin
        r_rs1  <= rf_rdata1_i;
        r_rs2  <= rf_rdata2_i;
        r_func <= func_t'(r_instr[FUNC_MSB:FUNC_LSB]);
        r_imm  <= r_instr[IMM_MSB:IMM_LSB];
      end
    end
  end

  assign w_wb    = (r_state == WB);
  assign w_rd_nz = (r_instr[RD_MSB:RD_LSB] != '0);

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic w_illegal;
  assign w_illegal = !func_is_legal(r_instr[FUNC_MSB:FUNC_LSB]);
  assign rf_we_o   = w_wb && w_rd_nz && !w_illegal;
  assign err_o     = w_wb && w_illegal;
`else
  assign rf_we_o   = w_wb && w_rd_nz;
  assign err_o     = 1'b0;
`endif

  assign instr_ready_o = (r_state == IDLE);
  assign rf_raddr1_o   = r_instr[RS1_MSB:RS1_LSB];
  assign rf_raddr2_o   = r_instr[RS2_MSB:RS2_LSB];
  assign rs1_data_o    = r_rs1;
  assign rs2_data_o    = r_rs2;
  assign func_o        = r_func;
  assign imm_o         = r_imm;
  assign rf_waddr_o    = r_instr[RD_MSB:RD_LSB];
  assign rf_wdata_o    = alu_result_i;
  assign done_o        = w_wb;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with a behavioural RF/ALU environment and an instruction-level reference model.
// Honours ALU_ISSUE_ILLEGAL_EN for the expected err_o / write suppression.
module tb_alu_issue;
  import simple_processor_pkg::*;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        instr_valid_i;
  logic [15:0] instr_i;
  logic        instr_ready_o;
  logic [2:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  func_t       func_o;
  logic [5:0]  imm_o;
  logic [31:0] alu_result_i;
  logic        rf_we_o;
  logic [2:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        done_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  alu_issue dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .func_o(func_o), .imm_o(imm_o), .alu_result_i(alu_result_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .done_o(done_o), .err_o(err_o)
  );

  function automatic logic [31:0] sext6(input logic [5:0] v);
    return {{26{v[5]}}, v};
  endfunction

  // Environment: synchronous-read register file plus combinational ALU.
  logic [31:0] rf_mem [8];
  logic        tb_we;
  logic [2:0]  tb_waddr;
  logic [31:0] tb_wdata;

  always @(posedge clk_i) begin
    if (tb_we) rf_mem[tb_waddr] <= tb_wdata;
    else if (rf_we_o) rf_mem[rf_waddr_o] <= rf_wdata_o;
    rf_rdata1_i <= rf_mem[rf_raddr1_o];
    rf_rdata2_i <= rf_mem[rf_raddr2_o];
  end

  always_comb begin
    alu_result_i = rs1_data_o;
    case (func_o)
      ADD:     alu_result_i = rs1_data_o + rs2_data_o;
      SUB:     alu_result_i = rs1_data_o - rs2_data_o;
      ADDI:    alu_result_i = rs1_data_o + sext6(imm_o);
      default: alu_result_i = rs1_data_o;
    endcase
  end

  // Reference model: one instruction in flight, retiring 3 cycles after its accept.
  int          m_cnt = 0;
  int          ret_idx = 0;
  bit          m_started = 1'b0;
  logic [15:0] m_instr;
  logic [31:0] m_a, m_b, m_res;
  logic        m_ill, m_we;
  logic [31:0] ref_rf [8];

  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      m_cnt = 0;
    end else begin
      if (tb_we) ref_rf[tb_waddr] = tb_wdata;
      if (m_cnt == 0) begin
        if (instr_valid_i) begin
          m_instr   = instr_i;
          m_started = 1'b1;
          m_a       = ref_rf[instr_i[8:6]];
          m_b       = ref_rf[instr_i[5:3]];
          m_ill     = (instr_i[15:12] > 4'd2);
          case (instr_i[15:12])
            4'h0:    m_res = m_a + m_b;
            4'h1:    m_res = m_a - m_b;
            4'h2:    m_res = m_a + sext6(instr_i[5:0]);
            default: m_res = m_a;
          endcase
          m_we  = (instr_i[11:9] != 3'd0) && !(m_ill && ILL_EN);
          m_cnt = 1;
        end
      end else if (m_cnt < 3) begin
        m_cnt = m_cnt + 1;
      end else begin
        if (m_we) ref_rf[m_instr[11:9]] = m_res;
        ret_idx = ret_idx + 1;
        m_cnt   = 0;
      end
    end
  end

  // Hand-computed results of the directed sequence, in retirement order.
  localparam logic [31:0] LIT_WDATA [8] = '{32'd12, 32'hFFFF_FFFE, 32'd8, 32'd15,
                                            32'd10, 32'd24, 32'd36, 32'd36};
  localparam logic        LIT_WE    [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                                            !ILL_EN, 1'b1, 1'b1, 1'b1};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("ready", 32'(instr_ready_o), 32'(m_cnt == 0));
    chk("done", 32'(done_o), 32'(m_cnt == 3));
    chk("we", 32'(rf_we_o), 32'(m_cnt == 3 && m_we));
    chk("err", 32'(err_o), 32'(m_cnt == 3 && m_ill && ILL_EN));
    if (!m_started) begin
      chk("rst_func", 32'(func_o), 32'(ADD));
      chk("rst_imm", 32'(imm_o), 32'd0);
      chk("rst_rs1", rs1_data_o, 32'd0);
      chk("rst_rs2", rs2_data_o, 32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    end
    if (m_cnt == 1) begin
      chk("raddr1", 32'(rf_raddr1_o), 32'(m_instr[8:6]));
      chk("raddr2", 32'(rf_raddr2_o), 32'(m_instr[5:3]));
    end
    if (m_cnt == 3) begin
      chk("waddr", 32'(rf_waddr_o), 32'(m_instr[11:9]));
      chk("wdata", rf_wdata_o, m_res);
      chk("func", 32'(func_o), 32'(m_instr[15:12]));
      chk("imm", 32'(imm_o), 32'(m_instr[5:0]));
      chk("rs1_data", rs1_data_o, m_a);
      chk("rs2_data", rs2_data_o, m_b);
      if (ret_idx < 8) begin
        chk("lit_wdata", rf_wdata_o, LIT_WDATA[ret_idx]);
        chk("lit_we", 32'(rf_we_o), 32'(LIT_WE[ret_idx]));
        if (ret_idx == 2) chk("lit_imm", 32'(imm_o), 32'h3E);
      end
    end
  end

  task automatic load(input logic [2:0] a, input logic [31:0] v);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
    @(posedge clk_i); #1;
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input bit keep);
    bit acc;
    acc = 1'b0;
    instr_valid_i = 1'b1;
    instr_i = ins;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_i);
      acc = instr_ready_o;
      @(posedge clk_i); #1;
    end
    if (!acc) begin
      $display("FAIL accept_timeout: ready never seen for instr %0h", ins);
      $fatal(1);
    end
    if (!keep) instr_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    instr_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] f;
    int sel;
    arst_ni = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) @(posedge clk_i);
    #1 arst_ni = 1'b1;
    for (int i = 0; i < 8; i++) load(3'(i), 32'd0);

    load(3'd1, 32'd5); load(3'd2, 32'd7);
    issue({4'h0, 3'd3, 3'd1, 3'd2, 3'd0}, 1'b0); wait_idle();
    load(3'd1, 32'd3); load(3'd2, 32'd5);
    issue({4'h1, 3'd4, 3'd1, 3'd2, 3'd0}, 1'b0); wait_idle();
    load(3'd1, 32'd10);
    issue({4'h2, 3'd5, 3'd1, 6'h3E}, 1'b0); wait_idle();
    issue({4'h0, 3'd0, 3'd1, 3'd2, 3'd0}, 1'b0); wait_idle();
    issue({4'hF, 3'd6, 3'd1, 3'd2, 3'd0}, 1'b0); wait_idle();
    // Valid held across a dependent pair: r2 = r3 + r3, then r7 = r2 + r3.
    issue({4'h0, 3'd2, 3'd3, 3'd3, 3'd0}, 1'b1);
    issue({4'h0, 3'd7, 3'd2, 3'd3, 3'd0}, 1'b0); wait_idle();
    // Abort r7 = r1 + r1 in EXEC; r7 must keep 36.
    issue({4'h0, 3'd7, 3'd1, 3'd1, 3'd0}, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1 arst_ni = 1'b0;
    @(posedge clk_i); #1 arst_ni = 1'b1;
    issue({4'h0, 3'd6, 3'd7, 3'd0, 3'd0}, 1'b0); wait_idle();

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        load(3'($urandom_range(1, 7)), $urandom);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
      sel = $urandom_range(0, 7);
      if (sel < 3) f = 4'h0;
      else if (sel < 5) f = 4'h1;
      else if (sel < 7) f = 4'h2;
      else f = 4'($urandom_range(3, 15));
      issue({f, 3'($urandom), 3'($urandom), 6'($urandom)}, 1'($urandom));
    end
    wait_idle();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
